// File: rtl/canny_frame_sequencer.sv
// -----------------------------------------------------------------------------
// canny_frame_sequencer
//
// Per-frame controller for the Canny/grayscale pixel core inside the VIP
// flow-control wrapper. It latches the decoded control-packet dimensions,
// requests the outgoing control packet before each frame, gates core reads so
// the number of pixels in flight stays bounded, counts input/output beats,
// drains the pipeline at end of frame and tags the last output pixel with
// end-of-video.
//
// Handshake semantics (one place, applies to every beat signal here):
//   in_beat / out_beat are "transfer happened" strobes: each cycle they are
//   high counts as exactly one accepted pixel. read_enable is a registered
//   permission that the wrapper ANDs into the core read, so a beat is only
//   expected while read_enable is high. vip_ctrl_valid is a 1-cycle pulse;
//   vip_ctrl_send is a 1-cycle request issued only while vip_ctrl_busy is low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   vip_ctrl_valid             decoded control packet present (pulse)
//   width_in/height_in         decoded frame dimensions
//   interlaced_in              decoded interlace field
//   vip_ctrl_busy              encoder cannot accept a control packet
//   vip_ctrl_send              1-cycle request to send a control packet
//   width_out/height_out       latched frame dimensions
//   interlaced_out             latched interlace field
//   in_beat, in_eov            pixel accepted into core, with end-of-video
//   out_beat                   pixel accepted by the downstream encoder
//   core_empty                 core output FIFO empty
//   read_enable                gate for the core read signal
//   eov_out                    current output beat is the last of the frame
//   frame_active               high while streaming or draining
//   frame_err                  sticky frame-length / protocol error
//   inflight                   pixels accepted but not yet output
// -----------------------------------------------------------------------------
module canny_frame_sequencer #(
   parameter int MAX_WIDTH  = 1920,
   parameter int MAX_HEIGHT = 1080,
   parameter int PIPE_DEPTH = 64,
   parameter int CNT_W      = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vip_ctrl_valid,
   input  logic [15:0]      width_in,
   input  logic [15:0]      height_in,
   input  logic [3:0]       interlaced_in,
   input  logic             vip_ctrl_busy,
   output logic             vip_ctrl_send,
   output logic [15:0]      width_out,
   output logic [15:0]      height_out,
   output logic [3:0]       interlaced_out,
   input  logic             in_beat,
   input  logic             in_eov,
   input  logic             out_beat,
   input  logic             core_empty,
   output logic             read_enable,
   output logic             eov_out,
   output logic             frame_active,
   output logic             frame_err,
   output logic [CNT_W-1:0] inflight
);

   typedef enum logic [1:0] {
      WAIT_CTRL = 2'd0,
      SEND_CTRL = 2'd1,
      STREAM    = 2'd2,
      DRAIN     = 2'd3
   } state_t;

   // Read gating threshold: one below the pipe depth so a beat already in
   // flight when read_enable falls still fits.
   localparam logic [CNT_W-1:0] INF_LIMIT = CNT_W'(PIPE_DEPTH - 1);
   localparam logic [CNT_W-1:0] LEN_CLAMP = {CNT_W{1'b1}};

   state_t           state, state_next;
   logic [CNT_W-1:0] in_cnt, in_cnt_next;
   logic [CNT_W-1:0] out_cnt, out_cnt_next;
   logic [CNT_W-1:0] frame_len, frame_len_next;
   logic [CNT_W-1:0] in_cnt_inc;
   logic [15:0]      width_next, height_next;
   logic [3:0]       interlaced_next;
   logic [15:0]      sh_width, sh_width_next;
   logic [15:0]      sh_height, sh_height_next;
   logic [3:0]       sh_interlaced, sh_interlaced_next;
   logic             pending, pending_next;
   logic             err_next;
   logic             send_next;
   logic             read_enable_next;
   logic [31:0]      prod;

   assign inflight     = in_cnt - out_cnt;
   assign frame_active = (state == STREAM) || (state == DRAIN);
   // Only the final pixel of a draining frame leaves with one pixel in flight.
   assign eov_out      = (state == DRAIN) && (inflight == CNT_W'(1));
   assign in_cnt_inc   = in_cnt + CNT_W'(1);

   always_comb begin
      state_next         = state;
      in_cnt_next        = in_cnt;
      out_cnt_next       = out_cnt;
      frame_len_next     = frame_len;
      width_next         = width_out;
      height_next        = height_out;
      interlaced_next    = interlaced_out;
      sh_width_next      = sh_width;
      sh_height_next     = sh_height;
      sh_interlaced_next = sh_interlaced;
      pending_next       = pending;
      err_next           = frame_err;
      send_next          = 1'b0;
      prod               = 32'd0;

      // A packet arriving while a frame is busy is parked; newest wins.
      if (vip_ctrl_valid && (state != WAIT_CTRL)) begin
         sh_width_next      = width_in;
         sh_height_next     = height_in;
         sh_interlaced_next = interlaced_in;
         pending_next       = 1'b1;
      end

      // Output beats are counted in any state; an underflow is an error.
      if (out_beat) begin
         if (inflight == '0) err_next = 1'b1;
         else                out_cnt_next = out_cnt + CNT_W'(1);
      end

      if (in_beat && (state != STREAM)) err_next = 1'b1;

      case (state)
         WAIT_CTRL: begin
            if (vip_ctrl_valid || pending) begin
               if (vip_ctrl_valid) begin
                  width_next      = width_in;
                  height_next     = height_in;
                  interlaced_next = interlaced_in;
               end else begin
                  width_next      = sh_width;
                  height_next     = sh_height;
                  interlaced_next = sh_interlaced;
               end
               pending_next = 1'b0;
               state_next   = SEND_CTRL;
               prod = 32'(width_next) * 32'(height_next);
               if ((prod == 32'd0) || (prod[31:CNT_W] != '0)) begin
                  err_next       = 1'b1;
                  frame_len_next = LEN_CLAMP;
               end else begin
                  frame_len_next = prod[CNT_W-1:0];
               end
            end
         end
         SEND_CTRL: begin
            if (!vip_ctrl_busy) begin
               send_next    = 1'b1;
               in_cnt_next  = '0;
               out_cnt_next = '0;
               state_next   = STREAM;
            end
         end
         STREAM: begin
            if (in_beat) begin
               in_cnt_next = in_cnt_inc;
               if (in_eov) begin
                  state_next = DRAIN;
                  if (in_cnt_inc != frame_len) err_next = 1'b1;
               end else if (in_cnt_inc == frame_len) begin
                  // Frame reached its length without an end-of-video tag.
                  state_next = DRAIN;
                  err_next   = 1'b1;
               end
            end
         end
         DRAIN: begin
            if ((inflight == '0) && core_empty) state_next = WAIT_CTRL;
         end
         default: state_next = WAIT_CTRL;
      endcase

      // Registered from next-cycle values so read_enable tracks the
      // registered inflight count without an extra cycle of lag.
      read_enable_next = (state_next == STREAM) &&
                         ((in_cnt_next - out_cnt_next) < INF_LIMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= WAIT_CTRL;
         in_cnt         <= '0;
         out_cnt        <= '0;
         frame_len      <= '0;
         width_out      <= 16'(MAX_WIDTH);
         height_out     <= 16'(MAX_HEIGHT);
         interlaced_out <= '0;
         sh_width       <= '0;
         sh_height      <= '0;
         sh_interlaced  <= '0;
         pending        <= 1'b0;
         frame_err      <= 1'b0;
         vip_ctrl_send  <= 1'b0;
         read_enable    <= 1'b0;
      end else begin
         state          <= state_next;
         in_cnt         <= in_cnt_next;
         out_cnt        <= out_cnt_next;
         frame_len      <= frame_len_next;
         width_out      <= width_next;
         height_out     <= height_next;
         interlaced_out <= interlaced_next;
         sh_width       <= sh_width_next;
         sh_height      <= sh_height_next;
         sh_interlaced  <= sh_interlaced_next;
         pending        <= pending_next;
         frame_err      <= err_next;
         vip_ctrl_send  <= send_next;
         read_enable    <= read_enable_next;
      end
   end

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_canny_frame_sequencer
//
// Directed bench: per-cycle vector table (inputs + expected outputs after the
// clock edge) plus hand-written sequences for read throttling, asynchronous
// reset mid-frame and error boundaries.
// -----------------------------------------------------------------------------
module tb_canny_frame_sequencer;

   localparam int CNT_W = 22;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             vip_ctrl_valid;
   logic [15:0]      width_in, height_in;
   logic [3:0]       interlaced_in;
   logic             vip_ctrl_busy;
   logic             vip_ctrl_send;
   logic [15:0]      width_out, height_out;
   logic [3:0]       interlaced_out;
   logic             in_beat, in_eov, out_beat, core_empty;
   logic             read_enable, eov_out, frame_active, frame_err;
   logic [CNT_W-1:0] inflight;

   int checks   = 0;
   int failures = 0;

   canny_frame_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .vip_ctrl_valid(vip_ctrl_valid), .width_in(width_in),
      .height_in(height_in), .interlaced_in(interlaced_in),
      .vip_ctrl_busy(vip_ctrl_busy), .vip_ctrl_send(vip_ctrl_send),
      .width_out(width_out), .height_out(height_out),
      .interlaced_out(interlaced_out),
      .in_beat(in_beat), .in_eov(in_eov), .out_beat(out_beat),
      .core_empty(core_empty), .read_enable(read_enable),
      .eov_out(eov_out), .frame_active(frame_active),
      .frame_err(frame_err), .inflight(inflight)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic       ctrl;
      logic [15:0] w, h;
      logic       busy, ib, ie, ob, ce;
      logic       e_send, e_re, e_act, e_eov, e_err;
      int         e_inf, e_w, e_h;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic ctrl, input int w, input int h,
                      input logic busy, input logic ib, input logic ie,
                      input logic ob, input logic ce,
                      input logic e_send, input logic e_re, input logic e_act,
                      input logic e_eov, input logic e_err,
                      input int e_inf, input int e_w, input int e_h);
      vec_t v;
      v.ctrl = ctrl; v.w = 16'(w); v.h = 16'(h); v.busy = busy;
      v.ib = ib; v.ie = ie; v.ob = ob; v.ce = ce;
      v.e_send = e_send; v.e_re = e_re; v.e_act = e_act;
      v.e_eov = e_eov; v.e_err = e_err;
      v.e_inf = e_inf; v.e_w = e_w; v.e_h = e_h;
      vq.push_back(v);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      vip_ctrl_valid = 1'b0; width_in = '0; height_in = '0;
      interlaced_in = '0; vip_ctrl_busy = 1'b0;
      in_beat = 1'b0; in_eov = 1'b0; out_beat = 1'b0; core_empty = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         vip_ctrl_valid = vq[i].ctrl; width_in = vq[i].w; height_in = vq[i].h;
         vip_ctrl_busy = vq[i].busy; in_beat = vq[i].ib; in_eov = vq[i].ie;
         out_beat = vq[i].ob; core_empty = vq[i].ce;
         tick();
         chk($sformatf("%s[%0d] send", tag, i), 32'(vip_ctrl_send), 32'(vq[i].e_send));
         chk($sformatf("%s[%0d] read_enable", tag, i), 32'(read_enable), 32'(vq[i].e_re));
         chk($sformatf("%s[%0d] frame_active", tag, i), 32'(frame_active), 32'(vq[i].e_act));
         chk($sformatf("%s[%0d] eov_out", tag, i), 32'(eov_out), 32'(vq[i].e_eov));
         chk($sformatf("%s[%0d] frame_err", tag, i), 32'(frame_err), 32'(vq[i].e_err));
         chk($sformatf("%s[%0d] inflight", tag, i), 32'(inflight), 32'(vq[i].e_inf));
         chk($sformatf("%s[%0d] width_out", tag, i), 32'(width_out), 32'(vq[i].e_w));
         chk($sformatf("%s[%0d] height_out", tag, i), 32'(height_out), 32'(vq[i].e_h));
      end
      vq.delete();
      idle();
   endtask

   // Frame body helper: n beats (last with eov), then n out beats, then back
   // to WAIT_CTRL. Expected values assume eov lands on the correct beat.
   task automatic add_frame(input int n, input int w, input int h,
                            input logic err);
      for (int k = 1; k < n; k++) add(0,0,0,0, 1,0,0,1, 0,1,1,0,err,k, w,h);
      add(0,0,0,0, 1,1,0,1, 0,0,1,0,err,n, w,h);
      for (int k = 1; k <= n; k++)
         add(0,0,0,0, 0,0,1,1, 0,0,1,(n-k == 1),err,n-k, w,h);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " send"}, 32'(vip_ctrl_send), 0);
      chk({tag, " read_enable"}, 32'(read_enable), 0);
      chk({tag, " eov_out"}, 32'(eov_out), 0);
      chk({tag, " frame_active"}, 32'(frame_active), 0);
      chk({tag, " frame_err"}, 32'(frame_err), 0);
      chk({tag, " inflight"}, 32'(inflight), 0);
      chk({tag, " width_out"}, 32'(width_out), 1920);
      chk({tag, " height_out"}, 32'(height_out), 1080);
      chk({tag, " interlaced_out"}, 32'(interlaced_out), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      idle();
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // 1: nominal 4x2 frame, core FIFO briefly non-empty at the end.
      add(1,4,2,0, 0,0,0,1, 0,0,0,0,0,0, 4,2);
      add(0,0,0,0, 0,0,0,1, 1,1,1,0,0,0, 4,2);
      for (int k = 1; k < 8; k++) add(0,0,0,0, 1,0,0,1, 0,1,1,0,0,k, 4,2);
      add(0,0,0,0, 1,1,0,1, 0,0,1,0,0,8, 4,2);
      for (int k = 1; k <= 8; k++)
         add(0,0,0,0, 0,0,1,1, 0,0,1,(8-k == 1),0,8-k, 4,2);
      add(0,0,0,0, 0,0,0,0, 0,0,1,0,0,0, 4,2);
      add(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 4,2);
      // 3: 4x4 with encoder busy for 5 cycles, then exactly one send pulse.
      add(1,4,4,1, 0,0,0,1, 0,0,0,0,0,0, 4,4);
      for (int k = 0; k < 4; k++) add(0,0,0,1, 0,0,0,1, 0,0,0,0,0,0, 4,4);
      add(0,0,0,0, 0,0,0,1, 1,1,1,0,0,0, 4,4);
      add(0,0,0,0, 0,0,0,1, 0,1,1,0,0,0, 4,4);
      add_frame(16, 4, 4, 1'b0);
      add(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 4,4);
      // 4: 4x2 with early eov on beat 5 -> short frame error.
      add(1,4,2,0, 0,0,0,1, 0,0,0,0,0,0, 4,2);
      add(0,0,0,0, 0,0,0,1, 1,1,1,0,0,0, 4,2);
      for (int k = 1; k < 5; k++) add(0,0,0,0, 1,0,0,1, 0,1,1,0,0,k, 4,2);
      add(0,0,0,0, 1,1,0,1, 0,0,1,0,1,5, 4,2);
      for (int k = 1; k <= 5; k++)
         add(0,0,0,0, 0,0,1,1, 0,0,1,(5-k == 1),1,5-k, 4,2);
      add(0,0,0,0, 0,0,0,1, 0,0,0,0,1,0, 4,2);
      run_table("t134");

      // 5: second packet (8x8) arrives mid-frame and is applied afterwards.
      do_reset();
      add(1,4,2,0, 0,0,0,1, 0,0,0,0,0,0, 4,2);
      add(0,0,0,0, 0,0,0,1, 1,1,1,0,0,0, 4,2);
      add(0,0,0,0, 1,0,0,1, 0,1,1,0,0,1, 4,2);
      add(1,8,8,0, 1,0,0,1, 0,1,1,0,0,2, 4,2);
      for (int k = 3; k < 8; k++) add(0,0,0,0, 1,0,0,1, 0,1,1,0,0,k, 4,2);
      add(0,0,0,0, 1,1,0,1, 0,0,1,0,0,8, 4,2);
      for (int k = 1; k <= 8; k++)
         add(0,0,0,0, 0,0,1,1, 0,0,1,(8-k == 1),0,8-k, 4,2);
      add(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 4,2);
      add(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 8,8);
      add(0,0,0,0, 0,0,0,1, 1,1,1,0,0,0, 8,8);
      add(0,0,0,0, 0,0,0,1, 0,1,1,0,0,0, 8,8);
      run_table("t5");

      // 2: 1920x1080 with no output -> reads throttle at 63 in flight.
      do_reset();
      vip_ctrl_valid = 1'b1; width_in = 16'd1920; height_in = 16'd1080;
      tick();
      idle();
      tick();
      chk("t2 send", 32'(vip_ctrl_send), 1);
      n = 0;
      for (int c = 0; c < 80 && read_enable; c++) begin
         in_beat = 1'b1;
         tick();
         n++;
      end
      in_beat = 1'b0;
      chk("t2 beats accepted", 32'(n), 63);
      chk("t2 inflight at limit", 32'(inflight), 63);
      chk("t2 read_enable low", 32'(read_enable), 0);
      repeat (3) tick();
      chk("t2 read_enable held low", 32'(read_enable), 0);
      out_beat = 1'b1;
      tick();
      out_beat = 1'b0;
      chk("t2 inflight after out", 32'(inflight), 62);
      chk("t2 read_enable reopens", 32'(read_enable), 1);
      chk("t2 frame_err", 32'(frame_err), 0);

      // 6: asynchronous reset mid-stream with 10 pixels in flight.
      do_reset();
      vip_ctrl_valid = 1'b1; width_in = 16'd1920; height_in = 16'd1080;
      interlaced_in = 4'h5;
      tick();
      idle();
      chk("t6 interlaced latched", 32'(interlaced_out), 5);
      tick();
      in_beat = 1'b1;
      repeat (10) tick();
      in_beat = 1'b0;
      chk("t6 inflight", 32'(inflight), 10);
      chk("t6 active", 32'(frame_active), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6 async reset");
      tick();
      rst_n = 1'b1;

      // Boundary: in_beat outside STREAM sets the sticky error.
      in_beat = 1'b1;
      tick();
      in_beat = 1'b0;
      chk("bnd in_beat idle err", 32'(frame_err), 1);
      chk("bnd in_beat idle inflight", 32'(inflight), 0);
      tick();
      chk("bnd err sticky", 32'(frame_err), 1);

      // Boundary: out_beat with nothing in flight.
      do_reset();
      out_beat = 1'b1;
      tick();
      out_beat = 1'b0;
      chk("bnd out underflow err", 32'(frame_err), 1);
      chk("bnd out underflow inflight", 32'(inflight), 0);

      // Boundary: zero-length frame flagged on entry to SEND_CTRL.
      do_reset();
      vip_ctrl_valid = 1'b1; width_in = 16'd0; height_in = 16'd5;
      tick();
      idle();
      chk("bnd zero len err", 32'(frame_err), 1);
      chk("bnd zero len width", 32'(width_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
